// File: rtl/backing_mem_responder.sv
// Memory-side responder behind the data cache: one outstanding request,
// line-aligned read bursts or single write acks after a fixed latency.
module backing_mem_responder #(
  parameter int MEM_WORDS  = 1024,
  parameter int LINE_WORDS = 4,
  parameter int LATENCY    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_last,
  output logic        busy
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int BW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [AW-1:0] LMASK = AW'(LINE_WORDS - 1);
  localparam logic [BW-1:0] LASTB = BW'(LINE_WORDS - 1);
  localparam logic [CW-1:0] LAT0  = CW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, BURST, WACK} state_e;

  state_e        state_q;
  logic [AW-1:0] base_q;
  logic [BW-1:0] beat_q;
  logic [CW-1:0] cnt_q;
  logic          wr_q;
  logic          ready_q;
  logic          valid_q;
  logic          last_q;
  logic [31:0]   rdata_q;
  logic          busy_q;

  logic [31:0]   mem_q [MEM_WORDS];

  logic [AW-1:0] idx_d;
  logic [BW-1:0] beat_d;
  logic          accept_d;
  logic          unused_addr;

  assign idx_d       = req_addr[AW+1:2];
  assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};
  assign beat_d      = beat_q + 1'b1;
  assign accept_d    = req_valid && ready_q && !rst;

  assign req_ready  = ready_q;
  assign resp_valid = valid_q;
  assign resp_last  = last_q;
  assign resp_rdata = rdata_q;
  assign busy       = busy_q;

  // Writes commit on the accept edge; storage is never reset.
  always_ff @(posedge clk) begin
    if (accept_d && req_write) begin
      for (int i = 0; i < 4; i++) begin
        if (req_wstrb[i]) begin
          mem_q[idx_d][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      beat_q  <= '0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            wr_q    <= req_write;
            base_q  <= idx_d & ~LMASK;
            beat_q  <= '0;
            cnt_q   <= LAT0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            valid_q <= 1'b1;
            if (wr_q) begin
              last_q  <= 1'b1;
              rdata_q <= '0;
              state_q <= WACK;
            end else begin
              last_q  <= (LINE_WORDS == 1);
              rdata_q <= mem_q[base_q];
              state_q <= BURST;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        BURST: begin
          if (resp_ready) begin
            if (beat_q == LASTB) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              rdata_q <= '0;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              beat_q  <= '0;
              state_q <= IDLE;
            end else begin
              // Prefetch the next word so beats stream without a gap.
              beat_q  <= beat_d;
              rdata_q <= mem_q[base_q + AW'(beat_d)];
              last_q  <= (beat_d == LASTB);
            end
          end
        end
        WACK: begin
          if (resp_ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_backing_mem_responder.sv
// Scoreboard bench: stimulus pushes expected beats, a negedge monitor
// pops and compares every transferred response beat.
module tb_backing_mem_responder;

  localparam int LAT = 3;
  localparam int LW  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        resp_ready = 1'b1;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_last;
  logic        busy;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        first;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  logic [31:0] model [1024];
  int          total = 0;
  int          bad = 0;
  int          xfers = 0;
  int          cyc = 0;
  int          acc_cyc = 0;

  backing_mem_responder #(
    .MEM_WORDS(1024), .LINE_WORDS(LW), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_last(resp_last),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      xfers++;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL stray_beat got=%h want=none", resp_rdata);
      end else begin
        e = q.pop_front();
        chk("rdata", resp_rdata, e.data);
        chk("last", 32'(resp_last), 32'(e.last));
        if (e.first) chk("latency", 32'(cyc - acc_cyc), LAT);
      end
    end
  end

  task automatic send(input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    logic [9:0] idx;
    int n;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_wstrb = s;
    idx = a[11:2];
    if (w) begin
      for (int i = 0; i < 4; i++)
        if (s[i]) model[idx][8*i +: 8] = d[8*i +: 8];
      q.push_back('{data: 32'h0, last: 1'b1, first: 1'b1});
    end else begin
      idx = idx & ~10'h3;
      for (int i = 0; i < LW; i++)
        q.push_back('{data: model[idx + 10'(i)],
                      last: (i == LW - 1), first: (i == 0)});
    end
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("accept_timeout", 32'(n), 0);
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    req_valid = 1'b0;
    req_write = ~w;
    req_addr  = '1;
    req_wdata = '1;
    req_wstrb = '1;
    chk("busy_after_accept", 32'(busy), 1);
    chk("ready_after_accept", 32'(req_ready), 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(q.size() == 0 && req_ready) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 500) chk("idle_timeout", 32'(q.size()), 0);
  endtask

  task automatic wait_xfers(input int target);
    int n = 0;
    while (xfers < target && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) chk("beat_timeout", 32'(xfers), 32'(target));
  endtask

  initial begin
    int x0;
    #3 rst = 1'b1;
    #1;
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_valid", 32'(resp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_last", 32'(resp_last), 0);
    chk("rst_rdata", resp_rdata, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      send(1'b1, 32'(i * 4), 32'h1000_0000 + 32'(i * 32'h0101), 4'hF);
      wait_idle();
    end
    send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    wait_idle();
    send(1'b1, 32'h20, 32'h11223344, 4'hF);
    wait_idle();

    send(1'b0, 32'h1C, 32'h0, 4'h0);
    wait_idle();
    chk("word4_model", model[4], 32'hDEADBEEF);

    send(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
    wait_idle();
    send(1'b0, 32'h2C, 32'h0, 4'h0);
    wait_idle();

    send(1'b1, 32'h1000, 32'hCAFEF00D, 4'hF);
    wait_idle();
    send(1'b0, 32'h0, 32'h0, 4'h0);
    wait_idle();

    x0 = xfers;
    send(1'b0, 32'h24, 32'h0, 4'h0);
    wait_xfers(x0 + 1);
    resp_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("bp_valid", 32'(resp_valid), 1);
      chk("bp_rdata", resp_rdata, 32'h1000_0909);
      chk("bp_last", 32'(resp_last), 0);
      @(posedge clk);
    end
    #1 resp_ready = 1'b1;
    wait_idle();
    chk("bp_xfers", 32'(xfers - x0), 4);

    x0 = xfers;
    send(1'b0, 32'h14, 32'h0, 4'h0);
    wait_xfers(x0 + 1);
    @(negedge clk);
    #2 rst = 1'b1;
    q.delete();
    #1;
    chk("mid_rst_valid", 32'(resp_valid), 0);
    chk("mid_rst_ready", 32'(req_ready), 1);
    chk("mid_rst_busy", 32'(busy), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("post_rst_idle", 32'(resp_valid), 0);
    x0 = xfers;
    send(1'b0, 32'h10, 32'h0, 4'h0);
    wait_idle();
    chk("post_rst_xfers", 32'(xfers - x0), 4);

    repeat (5) @(posedge clk);
    chk("queue_empty", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
